// File: rtl/mem_rr_arbiter_if.sv
// Bundle between mem_rr_arbiter, its requesters and the shared single-port resource.
// master is the arbiter's view; slave is the environment (requesters plus resource).
interface mem_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               busy;

    modport master (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one fixed-latency single-port resource.
// One access in flight at a time; read data returns with a one-hot rsp_valid pulse.
module mem_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_rr_arbiter_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic [CW-1:0] cnt;
    logic [IW-1:0] pick;
    logic          any;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        pick = ptr;
        any  = 1'b0;
        idx  = 0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IW'(idx);
            if (!any && bus.req[cand]) begin
                pick = cand;
                any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            sel           <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.mem_en    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state         <= ISSUE;
                        sel           <= pick;
                        bus.gnt       <= onehot(pick);
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.req_we[pick];
                        bus.mem_addr  <= bus.req_addr[int'(pick)*AW +: AW];
                        bus.mem_wdata <= bus.req_wdata[int'(pick)*DW +: DW];
                        bus.busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                    if (bus.mem_we) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                // cnt hits zero exactly in cycle ISSUE+RD_LAT, when mem_rdata is valid.
                WAIT: begin
                    if (cnt == '0) begin
                        state         <= RESP;
                        bus.rsp_rdata <= bus.mem_rdata;
                        bus.rsp_valid <= onehot(sel);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios, then random requester traffic
// checked against a transaction-timeline model of the arbitration rules.
module tb_mem_rr_arbiter;
    localparam int NREQ   = 4;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
    localparam int NCYC   = 1500;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    mem_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    // Resource model: 64 words at addr[7:2]; unwritten words return a fixed pattern.
    logic [DW-1:0] mem     [64];
    bit            mem_wr  [64];
    logic [DW-1:0] rd_pipe [RD_LAT];

    function automatic logic [DW-1:0] mem_init(input int idx);
        return 32'hDEAD_BEEF ^ (32'(idx ^ 8) << 4);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
            mem[bus.mem_addr[7:2]]    <= bus.mem_wdata;
            mem_wr[bus.mem_addr[7:2]] <= 1'b1;
        end
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0)
            rd_pipe[0] <= mem_wr[bus.mem_addr[7:2]] ? mem[bus.mem_addr[7:2]]
                                                    : mem_init(int'(bus.mem_addr[7:2]));
        else
            rd_pipe[0] <= $urandom;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    // Requester state used by the random phase and the reference model.
    logic        ra    [NREQ];
    logic        rwe   [NREQ];
    logic [31:0] raddr [NREQ];
    logic [31:0] rwd   [NREQ];
    logic [31:0] shadow[32];
    int          ptr_m, free_at, busy_lo, g_cyc, r_cyc, g_idx, r_idx, w, c;
    logic        g_we;
    logic [31:0] g_addr, g_wdata, r_data;

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_req(input int i, input logic act, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.req[i]                = act;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = addr;
        bus.req_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt),       32'h0);
        chk({tag, "_rspv"},  32'(bus.rsp_valid), 32'h0);
        chk({tag, "_rdata"}, bus.rsp_rdata,      32'h0);
        chk({tag, "_en"},    32'(bus.mem_en),    32'h0);
        chk({tag, "_we"},    32'(bus.mem_we),    32'h0);
        chk({tag, "_addr"},  bus.mem_addr,       32'h0);
        chk({tag, "_wdata"}, bus.mem_wdata,      32'h0);
        chk({tag, "_busy"},  32'(bus.busy),      32'h0);
    endtask

    task automatic new_txn(input int i);
        ra[i]    = 1'b1;
        rwe[i]   = 1'($urandom_range(0, 1));
        raddr[i] = 32'h80 + 32'($urandom_range(0, 31)) * 4;
        rwd[i]   = $urandom;
    endtask

    initial begin
        int rot_exp[5];
        rot_exp = '{3, 0, 1, 3, 0};
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        tick();
        chk_zero("rst");
        tick();
        rst_n = 1'b1;

        // Single write from requester 0.
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_0001);
        tick();
        chk("wr_gnt",   32'(bus.gnt),    32'h1);
        chk("wr_en",    32'(bus.mem_en), 32'h1);
        chk("wr_we",    32'(bus.mem_we), 32'h1);
        chk("wr_addr",  bus.mem_addr,    32'h10);
        chk("wr_wdata", bus.mem_wdata,   32'hA5A5_0001);
        chk("wr_busy1", 32'(bus.busy),   32'h1);
        set_req(0, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001);
        tick();
        chk("wr_busy0", 32'(bus.busy),      32'h0);
        chk("wr_en0",   32'(bus.mem_en),    32'h0);
        chk("wr_rspv",  32'(bus.rsp_valid), 32'h0);
        tick();
        chk("wr_rspv2", 32'(bus.rsp_valid), 32'h0);

        // Single read from requester 2.
        set_req(2, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        chk("rd_gnt",  32'(bus.gnt),    32'h4);
        chk("rd_en",   32'(bus.mem_en), 32'h1);
        chk("rd_we",   32'(bus.mem_we), 32'h0);
        chk("rd_addr", bus.mem_addr,    32'h20);
        set_req(2, 1'b0, 1'b0, 32'h20, 32'h0);
        tick();
        chk("rd_rspv_t2", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("rd_rspv_t3", 32'(bus.rsp_valid), 32'h0);
        chk("rd_busy_t3", 32'(bus.busy),      32'h1);
        tick();
        chk("rd_rspv",  32'(bus.rsp_valid), 32'h4);
        chk("rd_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);
        tick();
        chk("rd_busy0", 32'(bus.busy),      32'h0);
        chk("rd_rspv0", 32'(bus.rsp_valid), 32'h0);
        chk("rd_hold",  bus.rsp_rdata,      32'hDEAD_BEEF);

        // Contention from reset: four writes, granted 0..3 every two cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 32'h40 + 32'(i) * 4, 32'h1000_0000 + 32'(i));
        for (int k = 0; k < NREQ; k++) begin
            tick();
            chk("ct_gnt",  32'(bus.gnt), oh(k));
            chk("ct_addr", bus.mem_addr, 32'h40 + 32'(k) * 4);
            set_req(k, 1'b0, 1'b1, 32'h40 + 32'(k) * 4, 32'h1000_0000 + 32'(k));
            tick();
            chk("ct_gap", 32'(bus.gnt), 32'h0);
        end
        chk("ct_busy0", 32'(bus.busy), 32'h0);

        // Rotation: grant 1, then 1011 held continuously.
        set_req(1, 1'b1, 1'b1, 32'h50, 32'h5);
        tick();
        chk("rot_g1", 32'(bus.gnt), 32'h2);
        set_req(0, 1'b1, 1'b1, 32'h50, 32'h5);
        set_req(3, 1'b1, 1'b1, 32'h50, 32'h5);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rot_gap", 32'(bus.gnt), 32'h0);
            tick();
            chk("rot_gnt", 32'(bus.gnt), oh(rot_exp[k]));
        end
        bus.req = '0;
        tick();
        tick();
        chk("rot_busy0", 32'(bus.busy), 32'h0);

        // Reset while a read is waiting.
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        chk("mr_gnt", 32'(bus.gnt), 32'h1);
        set_req(0, 1'b0, 1'b0, 32'h20, 32'h0);
        tick();
        chk("mr_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_zero("mr");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mr_norsp", 32'(bus.rsp_valid), 32'h0);
            chk("mr_idle",  32'(bus.busy),      32'h0);
        end
        set_req(0, 1'b1, 1'b1, 32'h60, 32'h60);
        set_req(3, 1'b1, 1'b1, 32'h6C, 32'h6C);
        tick();
        chk("mr_ptr0", 32'(bus.gnt), 32'h1);
        set_req(0, 1'b0, 1'b1, 32'h60, 32'h60);
        tick();
        tick();
        chk("mr_next", 32'(bus.gnt), 32'h8);
        set_req(3, 1'b0, 1'b1, 32'h6C, 32'h6C);
        tick();

        // Late request during a read's WAIT is held off until IDLE.
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        chk("lt_gnt0", 32'(bus.gnt), 32'h1);
        set_req(0, 1'b0, 1'b0, 32'h20, 32'h0);
        tick();
        set_req(1, 1'b1, 1'b1, 32'h44, 32'h77);
        tick();
        chk("lt_wait", 32'(bus.gnt), 32'h0);
        tick();
        chk("lt_rspv", 32'(bus.rsp_valid), 32'h1);
        chk("lt_rgnt", 32'(bus.gnt),       32'h0);
        chk("lt_rdat", bus.rsp_rdata,      32'hDEAD_BEEF);
        tick();
        chk("lt_idle", 32'(bus.gnt),  32'h0);
        chk("lt_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("lt_gnt1", 32'(bus.gnt), 32'h2);
        chk("lt_addr", bus.mem_addr, 32'h44);
        set_req(1, 1'b0, 1'b1, 32'h44, 32'h77);
        tick();

        // Random traffic against the timeline model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = 32'h80; rwd[i] = 32'h0;
        end
        for (int i = 0; i < 32; i++) shadow[i] = mem_init(i + 32);
        ptr_m = 0; free_at = 0; busy_lo = 0; g_cyc = -1; r_cyc = -1;
        g_idx = 0; r_idx = 0; g_we = 1'b0; g_addr = '0; g_wdata = '0; r_data = '0;
        for (int n = 0; n < NCYC; n++) begin
            tick();
            c = cyc;
            chk("r_gnt",  32'(bus.gnt),       (c == g_cyc) ? oh(g_idx) : 32'h0);
            chk("r_en",   32'(bus.mem_en),    32'(c == g_cyc));
            chk("r_rspv", 32'(bus.rsp_valid), (c == r_cyc) ? oh(r_idx) : 32'h0);
            chk("r_busy", 32'(bus.busy),      32'(c >= busy_lo && c < free_at));
            if (c == g_cyc) begin
                chk("r_addr",  bus.mem_addr,    g_addr);
                chk("r_we",    32'(bus.mem_we), 32'(g_we));
                chk("r_wdata", bus.mem_wdata,   g_wdata);
            end
            if (c == r_cyc) chk("r_rdata", bus.rsp_rdata, r_data);
            for (int i = 0; i < NREQ; i++) begin
                if (c == g_cyc && i == g_idx) begin
                    if ($urandom_range(0, 1) == 1) new_txn(i);
                    else ra[i] = 1'b0;
                end else if (!ra[i] && $urandom_range(0, 2) == 0) begin
                    new_txn(i);
                end
                set_req(i, ra[i], rwe[i], raddr[i], rwd[i]);
            end
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && ra[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
            if (c >= free_at && w >= 0) begin
                g_cyc   = c + 1;
                g_idx   = w;
                g_we    = rwe[w];
                g_addr  = raddr[w];
                g_wdata = rwd[w];
                busy_lo = c + 1;
                if (rwe[w]) begin
                    shadow[int'(raddr[w][7:2]) - 32] = rwd[w];
                    free_at = c + 2;
                end else begin
                    r_cyc   = c + 2 + RD_LAT;
                    r_idx   = w;
                    r_data  = shadow[int'(raddr[w][7:2]) - 32];
                    free_at = c + 3 + RD_LAT;
                end
                ptr_m = (w + 1) % NREQ;
            end
        end
        bus.req = '0;
        for (int k = 0; k < RD_LAT + 4; k++) tick();
        chk("end_busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
